// File: rtl/parity_popcount_serial.sv
// parity_popcount_serial
//   Captures a DATA_W-bit word when start is accepted in IDLE, then scans it
//   STEP bits per clock. It accumulates the number of 1 bits. When the last
//   beat completes, it registers the one-count, the zero-count and the
//   even/odd parity flags, pulses done for one cycle and raises result_valid.
//   A scan can be cancelled with abort. An aborted scan produces no done
//   pulse and leaves result_valid low.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   abort        cancel an in-progress scan, sampled only in SCAN
//   data_in      word, captured on the accepted start edge
//   busy         high while scanning
//   done         one-cycle completion pulse
//   result_valid results hold a completed, non-aborted scan
//   ones_count   number of 1 bits in the captured word
//   zero_count   DATA_W - ones_count
//   even_parity  1 when ones_count is even
//   odd_parity   1 when ones_count is odd
module parity_popcount_serial #(
  parameter int DATA_W = 8,
  parameter int STEP   = 1,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [CNT_W-1:0]  ones_count,
  output logic [CNT_W-1:0]  zero_count,
  output logic              even_parity,
  output logic              odd_parity
);

  localparam int BEATS  = DATA_W / STEP;
  localparam int BEAT_W = $clog2(BEATS + 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_acc;
  logic [BEAT_W-1:0] r_beat;
  logic              r_busy;
  logic              r_done;
  logic              r_rv;
  logic [CNT_W-1:0]  r_ones;
  logic [CNT_W-1:0]  r_zeros;
  logic              r_even;
  logic              r_odd;

  logic [CNT_W-1:0]  w_step_pop;
  logic [CNT_W-1:0]  w_sum;
  logic              w_last;
  logic              w_accept;

  // Number of set bits in one STEP-wide slice.
  function automatic logic [CNT_W-1:0] f_popcount(input logic [STEP-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < STEP; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // The accumulator cannot overflow because its maximum value is DATA_W.
  assign w_step_pop = f_popcount(r_shift[STEP-1:0]);
  assign w_sum      = r_acc + w_step_pop;
  assign w_last     = (r_beat == BEAT_W'(BEATS - 1));
  assign w_accept   = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort takes priority over completion on the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_SCAN;
      S_SCAN: if (abort || w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rv    <= 1'b0;
      r_ones  <= '0;
      r_zeros <= '0;
      r_even  <= 1'b0;
      r_odd   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Result outputs keep their previous values until the new scan completes.
        r_shift <= data_in;
        r_acc   <= '0;
        r_beat  <= '0;
        r_busy  <= 1'b1;
        r_rv    <= 1'b0;
      end else if (r_state == S_SCAN) begin
        if (abort) begin
          r_busy <= 1'b0;
        end else begin
          r_acc   <= w_sum;
          r_shift <= r_shift >> STEP;
          r_beat  <= r_beat + BEAT_W'(1);
          if (w_last) begin
            r_ones  <= w_sum;
            r_zeros <= CNT_W'(DATA_W) - w_sum;
            r_even  <= ~w_sum[0];
            r_odd   <= w_sum[0];
            r_done  <= 1'b1;
            r_rv    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_rv;
  assign ones_count   = r_ones;
  assign zero_count   = r_zeros;
  assign even_parity  = r_even;
  assign odd_parity   = r_odd;

endmodule

// File: tb/tb_parity_popcount_serial.sv
// Testbench for parity_popcount_serial.
//   Two instances are exercised: instance A uses DATA_W=8, STEP=1, and
//   instance B uses DATA_W=16, STEP=4.
//   A transaction-level model predicts every output on every cycle. The
//   scenarios from the test plan are then pinned with literal expectations.
//   A randomized phase follows.
module tb_parity_popcount_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=8, STEP=1
  logic       a_start = 1'b0, a_abort = 1'b0;
  logic [7:0] a_din = '0;
  logic       a_busy, a_done, a_rv, a_even, a_odd;
  logic [3:0] a_ones, a_zeros;

  // Instance B: DATA_W=16, STEP=4
  logic        b_start = 1'b0, b_abort = 1'b0;
  logic [15:0] b_din = '0;
  logic        b_busy, b_done, b_rv, b_even, b_odd;
  logic [4:0]  b_ones, b_zeros;

  parity_popcount_serial #(.DATA_W(8), .STEP(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .data_in(a_din),
    .busy(a_busy), .done(a_done), .result_valid(a_rv), .ones_count(a_ones),
    .zero_count(a_zeros), .even_parity(a_even), .odd_parity(a_odd));

  parity_popcount_serial #(.DATA_W(16), .STEP(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .data_in(b_din),
    .busy(b_busy), .done(b_done), .result_valid(b_rv), .ones_count(b_ones),
    .zero_count(b_zeros), .even_parity(b_even), .odd_parity(b_odd));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted start loads a word and a countdown of
  // BEATS cycles. When the countdown expires, the results come from $countones.
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rv;
    logic        even;
    logic        odd;
    logic [7:0]  ones;
    logic [7:0]  zeros;
    logic [7:0]  rem;
    logic [31:0] word;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, logic st, logic ab, logic [31:0] din,
                                 int dw, int beats);
    mdl_t n;
    int c;
    n = m;
    n.done = 1'b0;
    if (!m.busy) begin
      if (st) begin
        n.busy = 1'b1;
        n.rv   = 1'b0;
        n.word = din;
        n.rem  = 8'(beats);
      end
    end else if (ab) begin
      n.busy = 1'b0;
    end else begin
      n.rem = m.rem - 8'd1;
      if (n.rem == 8'd0) begin
        c = $countones(m.word);
        n.ones  = 8'(c);
        n.zeros = 8'(dw - c);
        n.even  = ~c[0];
        n.odd   = c[0];
        n.done  = 1'b1;
        n.rv    = 1'b1;
        n.busy  = 1'b0;
      end
    end
    return n;
  endfunction

  mdl_t ma = '0;
  mdl_t mb = '0;

  always @(posedge clk) begin
    if (!rst_n) ma = '0;
    else ma = mstep(ma, a_start, a_abort, {24'd0, a_din}, 8, 8);
    #2;
    check("A.busy",  32'(a_busy),  32'(ma.busy));
    check("A.done",  32'(a_done),  32'(ma.done));
    check("A.rv",    32'(a_rv),    32'(ma.rv));
    check("A.ones",  32'(a_ones),  32'(ma.ones));
    check("A.zeros", 32'(a_zeros), 32'(ma.zeros));
    check("A.even",  32'(a_even),  32'(ma.even));
    check("A.odd",   32'(a_odd),   32'(ma.odd));
  end

  always @(posedge clk) begin
    if (!rst_n) mb = '0;
    else mb = mstep(mb, b_start, b_abort, {16'd0, b_din}, 16, 4);
    #2;
    check("B.busy",  32'(b_busy),  32'(mb.busy));
    check("B.done",  32'(b_done),  32'(mb.done));
    check("B.rv",    32'(b_rv),    32'(mb.rv));
    check("B.ones",  32'(b_ones),  32'(mb.ones));
    check("B.zeros", 32'(b_zeros), 32'(mb.zeros));
    check("B.even",  32'(b_even),  32'(mb.even));
    check("B.odd",   32'(b_odd),   32'(mb.odd));
  end

  // Called at a falling edge: requests a start on the next rising edge.
  task automatic start_a(input logic [7:0] d);
    a_din = d;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] d);
    b_din = d;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  // Counts busy cycles until done is seen. Returns at the falling edge of the done cycle.
  task automatic wait_a(output int bc);
    int n;
    bc = 0;
    n = 0;
    while (!a_done && n < 40) begin
      if (a_busy) bc++;
      @(negedge clk);
      n++;
    end
    check("A.done_seen", 32'(a_done), 32'd1);
  endtask

  task automatic wait_b(output int bc);
    int n;
    bc = 0;
    n = 0;
    while (!b_done && n < 40) begin
      if (b_busy) bc++;
      @(negedge clk);
      n++;
    end
    check("B.done_seen", 32'(b_done), 32'd1);
  endtask

  int bc;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst.busy",  32'(a_busy),  32'd0);
    check("rst.done",  32'(a_done),  32'd0);
    check("rst.rv",    32'(a_rv),    32'd0);
    check("rst.ones",  32'(a_ones),  32'd0);
    check("rst.zeros", 32'(a_zeros), 32'd0);
    check("rst.even",  32'(a_even),  32'd0);
    check("rst.odd",   32'(a_odd),   32'd0);
    rst_n = 1'b1;

    // 0xB5: five ones
    @(negedge clk);
    start_a(8'hB5);
    wait_a(bc);
    check("B5.busy_cycles", 32'(bc), 32'd8);
    check("B5.ones",  32'(a_ones),  32'd5);
    check("B5.zeros", 32'(a_zeros), 32'd3);
    check("B5.odd",   32'(a_odd),   32'd1);
    check("B5.even",  32'(a_even),  32'd0);
    check("B5.rv",    32'(a_rv),    32'd1);
    @(negedge clk);
    check("B5.done_pulse", 32'(a_done), 32'd0);

    // Back-to-back runs: the second start is asserted in the done cycle
    start_a(8'h00);
    wait_a(bc);
    check("b2b0.busy_cycles", 32'(bc), 32'd8);
    check("b2b0.ones", 32'(a_ones), 32'd0);
    check("b2b0.even", 32'(a_even), 32'd1);
    check("b2b0.idle_gap", 32'(a_busy), 32'd0);
    start_a(8'hFF);
    wait_a(bc);
    check("b2b1.busy_cycles", 32'(bc), 32'd8);
    check("b2b1.ones",  32'(a_ones),  32'd8);
    check("b2b1.zeros", 32'(a_zeros), 32'd0);
    check("b2b1.even",  32'(a_even),  32'd1);

    // A start during the scan is ignored
    @(negedge clk);
    start_a(8'h01);
    repeat (2) @(negedge clk);
    a_din = 8'hFF;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_a(bc);
    check("ign.ones", 32'(a_ones), 32'd1);
    check("ign.odd",  32'(a_odd),  32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ign.no_second_done", 32'(a_done), 32'd0);
      check("ign.no_restart", 32'(a_busy), 32'd0);
    end

    // Abort at beat 4 of 0xF0, after a 0x03 result
    start_a(8'h03);
    wait_a(bc);
    check("pre.ones", 32'(a_ones), 32'd2);
    @(negedge clk);
    start_a(8'hF0);
    repeat (4) @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abt.busy", 32'(a_busy), 32'd0);
    check("abt.done", 32'(a_done), 32'd0);
    check("abt.rv",   32'(a_rv),   32'd0);
    check("abt.ones", 32'(a_ones), 32'd2);
    check("abt.even", 32'(a_even), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abt.no_done", 32'(a_done), 32'd0);
    end

    // DATA_W=16, STEP=4
    start_b(16'hFFFF);
    wait_b(bc);
    check("w16a.busy_cycles", 32'(bc), 32'd4);
    check("w16a.ones",  32'(b_ones),  32'd16);
    check("w16a.zeros", 32'(b_zeros), 32'd0);
    check("w16a.even",  32'(b_even),  32'd1);
    @(negedge clk);
    start_b(16'h8001);
    wait_b(bc);
    check("w16b.busy_cycles", 32'(bc), 32'd4);
    check("w16b.ones",  32'(b_ones),  32'd2);
    check("w16b.zeros", 32'(b_zeros), 32'd14);
    check("w16b.even",  32'(b_even),  32'd1);

    // Asynchronous reset in mid-scan, between clock edges
    @(negedge clk);
    start_a(8'hAA);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.busy",  32'(a_busy),  32'd0);
    check("arst.done",  32'(a_done),  32'd0);
    check("arst.rv",    32'(a_rv),    32'd0);
    check("arst.ones",  32'(a_ones),  32'd0);
    check("arst.zeros", 32'(a_zeros), 32'd0);
    check("arst.even",  32'(a_even),  32'd0);
    check("arst.odd",   32'(a_odd),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_a(8'h07);
    wait_a(bc);
    check("post.ones", 32'(a_ones), 32'd3);
    check("post.odd",  32'(a_odd),  32'd1);
    check("post.even", 32'(a_even), 32'd0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 499) != 0);
      a_start = ($urandom_range(0, 3) == 0);
      a_abort = ($urandom_range(0, 15) == 0);
      a_din   = 8'($urandom);
      b_start = ($urandom_range(0, 3) == 0);
      b_abort = ($urandom_range(0, 15) == 0);
      b_din   = 16'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_start = 1'b0;
    a_abort = 1'b0;
    b_start = 1'b0;
    b_abort = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
